// File: rtl/code_lock_pkg.sv
// Shared types for the code lock: digit type, digit range limit and dialer FSM states.
// Pure declarations; no logic and no timing.
package code_lock_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t c_digit_max = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } dial_state_t;

endpackage

// File: rtl/code_dialer_store.sv
// Digit shift register with load validation; store update and o_err one cycle after i_load.
// No backpressure: a rejected load is dropped and flagged, never held.
module code_dialer_store
    import code_lock_pkg::*;
#(
    parameter int p_digits = 4,
    parameter int p_idx_w  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  digit_t             i_digit,
    input  logic               i_load,
    input  logic               i_start,
    input  logic               i_busy,
    input  logic [p_idx_w-1:0] i_rd_idx,
    output digit_t             o_rd_digit,
    output logic               o_err
);

    digit_t store_q [p_digits];
    digit_t store_d [p_digits];
    logic   err_q;
    logic   err_d;
    logic   reject;

    always_comb begin
        reject = (i_digit > c_digit_max) || i_busy || i_start;
        err_d  = i_load && reject;
        store_d = store_q;
        if (i_load && !reject) begin
            // Newest digit enters at slot 0; slot p_digits-1 holds the oldest and goes out first.
            store_d[0] = i_digit;
            for (int k = 1; k < p_digits; k++) begin
                store_d[k] = store_q[k-1];
            end
        end
    end

    always_comb begin
        o_rd_digit = '0;
        for (int k = 0; k < p_digits; k++) begin
            if (i_rd_idx == p_idx_w'(k)) begin
                o_rd_digit = store_q[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            store_q <= '{default: '0};
            err_q   <= 1'b0;
        end else begin
            store_q <= store_d;
            err_q   <= err_d;
        end
    end

    assign o_err = err_q;

endmodule

// File: rtl/code_dialer.sv
// Replays the stored code as paced (digit, strobe) pairs; first strobe one cycle after i_start.
// No backpressure: strobes are fixed-rate; i_abort stops the stream on the next cycle.
module code_dialer
    import code_lock_pkg::*;
#(
    parameter int p_digits = 4,
    parameter int p_gap    = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_digit,
    input  logic       i_load,
    input  logic       i_start,
    input  logic       i_abort,
    output logic [3:0] o_code,
    output logic       o_code_vld,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int c_idx_w = (p_digits > 1) ? $clog2(p_digits) : 1;
    localparam int c_gap_w = $clog2(p_gap + 1);

    dial_state_t        state_q;
    dial_state_t        state_d;
    logic [c_idx_w-1:0] idx_q;
    logic [c_idx_w-1:0] idx_d;
    logic [c_gap_w-1:0] gap_q;
    logic [c_gap_w-1:0] gap_d;
    digit_t             rd_digit;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = S_SEND;
                        idx_d   = c_idx_w'(p_digits - 1);
                    end
                end
                S_SEND: begin
                    if (idx_q != '0) begin
                        state_d = S_GAP;
                        gap_d   = c_gap_w'(p_gap - 1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_d = S_SEND;
                        idx_d   = idx_q - c_idx_w'(1);
                    end else begin
                        gap_d = gap_q - c_gap_w'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    // Outputs decode the state flops directly, so they track state with no extra cycle.
    assign o_code_vld = (state_q == S_SEND);
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);
    assign o_code     = o_code_vld ? rd_digit : 4'd0;

    code_dialer_store #(
        .p_digits (p_digits),
        .p_idx_w  (c_idx_w)
    ) u_store (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_digit    (i_digit),
        .i_load     (i_load),
        .i_start    (i_start),
        .i_busy     (o_busy),
        .i_rd_idx   (idx_q),
        .o_rd_digit (rd_digit),
        .o_err      (o_err)
    );

endmodule

// File: tb/tb_code_dialer.sv
// Scoreboard bench for code_dialer: stimulus queues expected strobes/done/err events,
// a negedge monitor pops and compares them. Instance 1: 4 digits, gap 3; instance 2: 1 digit, gap 1.
module tb_code_dialer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d1, d2;
    logic       ld1, st1, ab1, ld2, st2, ab2;
    logic [3:0] c1, c2;
    logic       v1, b1, dn1, e1, v2, b2, dn2, e2;

    always #5 clk = ~clk;

    code_dialer #(.p_digits(4), .p_gap(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_digit(d1), .i_load(ld1), .i_start(st1), .i_abort(ab1),
        .o_code(c1), .o_code_vld(v1), .o_busy(b1), .o_done(dn1), .o_err(e1)
    );

    code_dialer #(.p_digits(1), .p_gap(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_digit(d2), .i_load(ld2), .i_start(st2), .i_abort(ab2),
        .o_code(c2), .o_code_vld(v2), .o_busy(b2), .o_done(dn2), .o_err(e2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int inst;
        int cyc;
        int code;
    } ev_t;

    ev_t sq[$];
    ev_t dq[$];
    ev_t eq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic mon(input int inst, input logic vld, input logic [3:0] code,
                       input logic done, input logic err);
        ev_t e;
        if (vld) begin
            if (sq.size() == 0) chk($sformatf("unexpected_strobe_dut%0d", inst), int'(vld), 0);
            else begin
                e = sq.pop_front();
                chk("strobe_inst", inst, e.inst);
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_code", int'(code), e.code);
            end
        end else begin
            chk($sformatf("code_zero_when_idle_dut%0d", inst), int'(code), 0);
        end
        if (done) begin
            if (dq.size() == 0) chk($sformatf("unexpected_done_dut%0d", inst), int'(done), 0);
            else begin
                e = dq.pop_front();
                chk("done_inst", inst, e.inst);
                chk("done_cycle", cyc, e.cyc);
            end
        end
        if (err) begin
            if (eq.size() == 0) chk($sformatf("unexpected_err_dut%0d", inst), int'(err), 0);
            else begin
                e = eq.pop_front();
                chk("err_inst", inst, e.inst);
                chk("err_cycle", cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, v1, c1, dn1, e1);
        mon(1, v2, c2, dn2, e2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_load(input int inst, input logic [3:0] d, input bit rej);
        ev_t e;
        if (inst == 0) begin ld1 = 1'b1; d1 = d; end
        else begin ld2 = 1'b1; d2 = d; end
        if (rej) begin
            e.inst = inst; e.cyc = cyc + 1; e.code = 0;
            eq.push_back(e);
        end
        tick();
        ld1 = 1'b0;
        ld2 = 1'b0;
    endtask

    // codes: first-transmitted digit in the most significant used nibble.
    task automatic push_tx(input int inst, input int n, input logic [15:0] codes,
                           input int nstrobes, input bit with_done);
        ev_t e;
        int  ndig;
        int  gap;
        ndig = (inst == 0) ? 4 : 1;
        gap  = (inst == 0) ? 3 : 1;
        for (int k = 0; k < nstrobes; k++) begin
            e.inst = inst;
            e.cyc  = n + 1 + k * (gap + 1);
            e.code = int'(codes >> (4 * (ndig - 1 - k))) & 15;
            sq.push_back(e);
        end
        if (with_done) begin
            e.inst = inst;
            e.cyc  = n + 1 + (ndig - 1) * (gap + 1) + 1;
            e.code = 0;
            dq.push_back(e);
        end
    endtask

    task automatic start_tx(input int inst, input logic [15:0] codes, input int nstrobes,
                            input bit with_done, output int n);
        n = cyc;
        if (inst == 0) st1 = 1'b1;
        else st2 = 1'b1;
        push_tx(inst, n, codes, nstrobes, with_done);
        tick();
        st1 = 1'b0;
        st2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        d1 = '0; ld1 = 0; st1 = 0; ab1 = 0;
        d2 = '0; ld2 = 0; st2 = 0; ab2 = 0;
        repeat (3) tick();
        chk("reset_code", int'(c1), 0);
        chk("reset_vld", int'(v1), 0);
        chk("reset_busy", int'(b1), 0);
        chk("reset_done", int'(dn1), 0);
        chk("reset_err", int'(e1), 0);
        rst = 1'b0;
        tick();

        // Empty store after reset replays four zeros.
        start_tx(0, 16'h0000, 4, 1'b1, n);
        wait_until(n + 14);
        chk("busy_in_done_cycle", int'(b1), 1);
        tick();
        chk("busy_after_done", int'(b1), 0);
        tick();

        // Load 1,2,3,4; a start in the done cycle must be ignored.
        do_load(0, 4'd1, 1'b0);
        do_load(0, 4'd2, 1'b0);
        do_load(0, 4'd3, 1'b0);
        do_load(0, 4'd4, 1'b0);
        start_tx(0, 16'h1234, 4, 1'b1, n);
        wait_until(n + 14);
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        chk("busy_after_b2b_start", int'(b1), 0);
        wait_until(n + 20);

        // Out-of-range load, load while busy, start while in gap.
        do_load(0, 4'd12, 1'b1);
        start_tx(0, 16'h1234, 4, 1'b1, n);
        wait_until(n + 2);
        chk("busy_in_gap", int'(b1), 1);
        do_load(0, 4'd5, 1'b1);
        wait_until(n + 6);
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        wait_until(n + 16);

        // Abort the cycle after the second strobe, then a full replay.
        start_tx(0, 16'h1234, 2, 1'b0, n);
        wait_until(n + 6);
        ab1 = 1'b1;
        tick();
        ab1 = 1'b0;
        chk("abort_busy", int'(b1), 0);
        chk("abort_vld", int'(v1), 0);
        wait_until(n + 20);
        start_tx(0, 16'h1234, 4, 1'b1, n);
        wait_until(n + 16);

        // Start and load together in idle: load rejected, old code sent.
        n = cyc;
        st1 = 1'b1; ld1 = 1'b1; d1 = 4'd7;
        push_tx(0, n, 16'h1234, 4, 1'b1);
        begin
            ev_t e;
            e.inst = 0; e.cyc = n + 1; e.code = 0;
            eq.push_back(e);
        end
        tick();
        st1 = 1'b0; ld1 = 1'b0;
        wait_until(n + 16);

        // Reset during a gap clears outputs and store.
        start_tx(0, 16'h1234, 1, 1'b0, n);
        wait_until(n + 2);
        rst = 1'b1;
        tick();
        chk("midrst_busy", int'(b1), 0);
        chk("midrst_vld", int'(v1), 0);
        chk("midrst_done", int'(dn1), 0);
        chk("midrst_err", int'(e1), 0);
        chk("midrst_code", int'(c1), 0);
        rst = 1'b0;
        tick();
        start_tx(0, 16'h0000, 4, 1'b1, n);
        wait_until(n + 16);

        // Single-digit, gap-1 instance.
        do_load(1, 4'd8, 1'b0);
        start_tx(1, 16'h0008, 1, 1'b1, n);
        wait_until(n + 2);
        chk("dut2_busy_in_done", int'(b2), 1);
        tick();
        chk("dut2_busy_after_done", int'(b2), 0);
        do_load(1, 4'd6, 1'b0);
        do_load(1, 4'd9, 1'b0);
        do_load(1, 4'd10, 1'b1);
        start_tx(1, 16'h0009, 1, 1'b1, n);
        wait_until(n + 5);

        chk("strobes_outstanding", sq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);
        chk("errs_outstanding", eq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/code_dialer.md
# code_dialer

Code-entry transmitter for the code lock: stores a p_digits-long decimal code and replays it as a paced stream of (digit, valid-strobe) pairs. Its output has the same format as the code/valid pair the lock FSM receives from the switch encoder. Used as an auto-dialer in the lock top and as a stimulus source for lock-FSM benches. Digits are loaded one at a time and sent in entry order, oldest first.

## Interface
- p_digits, 4, code length in digits (≥1)
- p_gap, 3, idle cycles between consecutive strobes (≥1)

- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_digit  in  4  digit to load, valid values 0..9
- i_load  in  1  single-cycle pulse: shift i_digit into the code store
- i_start  in  1  single-cycle pulse: begin transmission of stored code
- i_abort  in  1  single-cycle pulse: stop transmission immediately
- o_code  out  4  transmitted digit; valid only while o_code_vld=1, 0 otherwise
- o_code_vld  out  1  one-cycle strobe per digit
- o_busy  out  1  transmission in progress
- o_done  out  1  one-cycle pulse after the last digit of a complete (non-aborted) transmission
- o_err  out  1  one-cycle pulse: load rejected

## Operation
- Store: p_digits × 4-bit registers d[0..p_digits-1]. Reset value is all 0.
- Accepted load: d[0]←i_digit, d[k]←d[k-1], oldest digit is discarded.
- Transmit order: d[p_digits-1] first, d[0] last. This is the same order the digits were entered.
- Load rejection: o_err pulses and the store is unchanged when any of the following holds:
  - i_digit>9
  - o_busy=1
  - i_start=1 in the same cycle
- FSM states: S_IDLE, S_SEND, S_GAP, S_DONE.
- Transitions:
  - S_IDLE→S_SEND on i_start, with index←p_digits-1.
  - S_SEND→S_GAP if index≠0. Gap counter loads p_gap-1.
  - S_SEND→S_DONE if index=0.
  - S_GAP→S_SEND when the gap counter reaches 0, with index←index-1.
  - S_DONE→S_IDLE unconditionally.
- Outputs, all registered from state:
  - o_code_vld=1 only in S_SEND.
  - o_code=d[index] in S_SEND, 0 otherwise.
  - o_busy=1 in S_SEND, S_GAP, S_DONE.
  - o_done=1 only in S_DONE.
- Abort: in any state, i_abort forces S_IDLE in the next cycle. There is no o_done and the store is preserved.
- Priority:
  - i_rst > i_abort > i_start > i_load.
  - i_start while busy is ignored, with no error.
  - i_abort in S_IDLE is a no-op.
- Reset mid-transmission: all outputs are 0 next cycle, the store is cleared, and the FSM goes to S_IDLE.
- Index width is $clog2(p_digits) (min 1). Gap counter width is $clog2(p_gap+1). No wrap is possible: the index never decrements below 0.

## Timing
- Reset values: o_code=0, o_code_vld=0, o_busy=0, o_done=0, o_err=0.
- Load sampled at cycle N: store updated and o_err (if rejected) visible at N+1.
- Start sampled at cycle N: strobes at cycles N+1+k·(p_gap+1), for k=0..p_digits-1.
- o_done at N+1+(p_digits-1)(p_gap+1)+1. o_busy is high from N+1 through the o_done cycle.
- Defaults (p_digits=4, p_gap=3): strobes at N+1, N+5, N+9, N+13; done at N+14; new start accepted from N+15.
- Back-to-back: i_start in the o_done cycle is ignored, because the FSM is still busy.
- Abort at cycle M: o_busy=0 and o_code_vld=0 at M+1.

## Structure
- Shared package code_lock_pkg:
  - digit_t (logic [3:0])
  - constant c_digit_max=9
  - dialer state enum (S_IDLE, S_SEND, S_GAP, S_DONE)
- Sub-module code_dialer_store holds the digit shift register with load validation and o_err generation. FSM and gap timer stay in code_dialer.

## Test plan
- Load 1,2,3,4 then i_start at N -> o_code_vld at N+1, N+5, N+9, N+13 carrying 1,2,3,4; o_done at N+14; o_busy low at N+15.
- After reset, start without loads -> four strobes all with o_code=0, then o_done.
- Load i_digit=12 -> o_err at next cycle, store unchanged (subsequent transmit still 1,2,3,4). Load 5 during busy -> o_err, transmission unaffected.
- i_abort in cycle after second strobe -> no further strobes, no o_done. Re-start -> full 1,2,3,4 replay.
- i_start and i_load(7) same cycle in idle -> transmission starts with the old code, o_err=1. i_start during S_GAP -> ignored, strobe timing unchanged.
- i_rst mid-S_GAP -> all outputs 0 next cycle; subsequent start transmits 0,0,0,0. Repeat with p_digits=1, p_gap=1: strobe at N+1, done at N+2.
